// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : load/store responder with WAIT_CYCLES wait states and a
//                  word-organised array. Option macro: DMEM_MISALIGN_TRAP_EN.
// Revision       : 1.0
// ============================================================================
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req,
    input  logic            i_rw,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_write_data,
    output logic            o_ready,
    output logic [XLEN-1:0] o_data,
    output logic            o_done,
    output logic            o_misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int ADR_W = IDX_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        count;
    logic              lat_rw;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [ADR_W-1:0]  lat_addr;
    logic [XLEN-1:0]   lat_wdata;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic              accept;
    logic              do_access;
    logic              a_rw;
    logic [1:0]        a_size;
    logic              a_unsigned;
    logic [ADR_W-1:0]  a_addr;
    logic [XLEN-1:0]   a_wdata;
    logic [IDX_W-1:0]  word_idx;
    logic              mis_flag;
    logic [XLEN-1:0]   rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   merged;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^i_address[XLEN-1:ADR_W];

    assign o_ready = (state != WAIT) && !i_reset;
    assign accept  = i_req && o_ready;

    // With no wait states the access happens on the accept edge itself,
    // so the request fields come straight from the ports.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            a_rw       = i_rw;
            a_size     = i_size;
            a_unsigned = i_unsigned;
            a_addr     = i_address[ADR_W-1:0];
            a_wdata    = i_write_data;
            do_access  = accept;
        end else begin
            a_rw       = lat_rw;
            a_size     = lat_size;
            a_unsigned = lat_unsigned;
            a_addr     = lat_addr;
            a_wdata    = lat_wdata;
            do_access  = (state == WAIT) && (count == 4'd0) && !i_reset;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_flag = ((a_size == 2'b01) && a_addr[0]) ||
                      (a_size[1] && (a_addr[1:0] != 2'b00));
`else
    assign mis_flag = 1'b0;
`endif

    // Lane selection ignores the low address bits a size cannot use, which
    // is exactly the forced-alignment behaviour.
    assign word_idx = a_addr[ADR_W-1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{a_addr[1:0], 3'b000} +: 8];
    assign rd_half  = rd_word[{a_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (a_size)
            2'b00:   load_data = {{(XLEN-8){rd_byte[7] & ~a_unsigned}}, rd_byte};
            2'b01:   load_data = {{(XLEN-16){rd_half[15] & ~a_unsigned}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merged = rd_word;
        case (a_size)
            2'b00:   merged[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            2'b01:   merged[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            default: merged = a_wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (do_access && a_rw && !mis_flag) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            o_done       <= 1'b0;
            o_data       <= '0;
            o_misaligned <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_data       <= '0;
            o_misaligned <= 1'b0;
            if (do_access) begin
                o_done       <= 1'b1;
                o_data       <= (a_rw || mis_flag) ? '0 : load_data;
                o_misaligned <= mis_flag;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        lat_rw       <= i_rw;
                        lat_size     <= i_size;
                        lat_unsigned <= i_unsigned;
                        lat_addr     <= i_address[ADR_W-1:0];
                        lat_wdata    <= i_write_data;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
